// File: rtl/or1_rr_arb.sv
// ---------------------------------------------------------------------------
// or1_rr_arb
//
// Round-robin arbiter that shares one resource among up to 8 requesters.
// A grant is registered, one-hot and held while its owner keeps requesting,
// up to MAXHOLD consecutive cycles.  When that limit is reached the grant is
// revoked, TIMEOUT pulses for one cycle and the owner is masked out of
// arbitration until it drops its request.  Every grant is followed by at
// least one IDLE cycle, which gives the resource a clean handoff.
//
// Parameters:
//   N        number of requesters (2..8)
//   MAXHOLD  maximum consecutive grant cycles (>= 1)
//   CW       hold-counter width (derived from MAXHOLD)
//
// Ports:
//   CLK      clock; all state updates on the rising edge
//   RSTN     asynchronous active-low reset
//   REQ      level request per requester, bit i = requester i
//   GNT      registered one-hot grant, or all zero
//   OWNER    index of the current or most recent grantee
//   BUSY     high while any GNT bit is high
//   TIMEOUT  one-cycle pulse on a forced revoke
// ---------------------------------------------------------------------------
module or1_rr_arb #(
    parameter int N       = 4,
    parameter int MAXHOLD = 15,
    parameter int CW      = $clog2(MAXHOLD + 1)
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [N-1:0]         REQ,
    output logic [N-1:0]         GNT,
    output logic [$clog2(N)-1:0] OWNER,
    output logic                 BUSY,
    output logic                 TIMEOUT
);

    localparam int PW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [N-1:0]    mask, mask_nxt;
    logic [N-1:0]    gnt_nxt;
    logic [PW-1:0]   owner_nxt;
    logic            busy_nxt;
    logic            timeout_nxt;

    logic [N-1:0]    elig;
    logic            found;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   owner_inc;

    assign elig = REQ & ~mask;

    // Priority search starting at ptr.  Offsets are scanned from the far
    // end down to zero so the closest eligible requester is written last
    // and therefore wins.
    always_comb begin : winner_search
        int j;
        found  = 1'b0;
        winner = '0;
        j      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (elig[j]) begin
                found  = 1'b1;
                winner = PW'(j);
            end
        end
    end

    // Pointer value after the current owner lets go: the next index, mod N.
    assign owner_inc = (OWNER == PW'(N - 1)) ? '0 : OWNER + PW'(1);

    // State and output registers; all of them reset asynchronously so the
    // grant drops the moment RSTN falls.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            mask    <= '0;
            GNT     <= '0;
            OWNER   <= '0;
            BUSY    <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            mask    <= mask_nxt;
            GNT     <= gnt_nxt;
            OWNER   <= owner_nxt;
            BUSY    <= busy_nxt;
            TIMEOUT <= timeout_nxt;
        end
    end

    // Next-state and next-output logic.  A mask bit clears whenever its
    // request is seen low, in either state; a timeout sets the owner's bit
    // afterwards, and since the owner is requesting in that case the two
    // never collide.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        mask_nxt    = mask & REQ;
        gnt_nxt     = GNT;
        owner_nxt   = OWNER;
        busy_nxt    = BUSY;
        timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt         = '0;
                    gnt_nxt[winner] = 1'b1;
                    owner_nxt       = winner;
                    busy_nxt        = 1'b1;
                    cnt_nxt         = CW'(1);
                    state_nxt       = GRANT;
                end
            end
            GRANT: begin
                if (!REQ[OWNER]) begin
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = owner_inc;
                    state_nxt = IDLE;
                end else if (cnt == CW'(MAXHOLD)) begin
                    gnt_nxt         = '0;
                    busy_nxt        = 1'b0;
                    timeout_nxt     = 1'b1;
                    mask_nxt[OWNER] = 1'b1;
                    ptr_nxt         = owner_inc;
                    state_nxt       = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_or1_rr_arb.sv
// ---------------------------------------------------------------------------
// tb_or1_rr_arb
//
// Directed bench for or1_rr_arb.  Instance A uses N=4, MAXHOLD=4; instance B
// uses N=2, MAXHOLD=1.  Both share one clock.  Inputs change and outputs are
// sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_or1_rr_arb;

    logic       clk;
    logic       rstn_a;
    logic [3:0] req_a;
    logic [3:0] gnt_a;
    logic [1:0] owner_a;
    logic       busy_a;
    logic       timeout_a;

    logic       rstn_b;
    logic [1:0] req_b;
    logic [1:0] gnt_b;
    logic [0:0] owner_b;
    logic       busy_b;
    logic       timeout_b;

    int checks;
    int errors;

    or1_rr_arb #(.N(4), .MAXHOLD(4)) dut_a (
        .CLK     (clk),
        .RSTN    (rstn_a),
        .REQ     (req_a),
        .GNT     (gnt_a),
        .OWNER   (owner_a),
        .BUSY    (busy_a),
        .TIMEOUT (timeout_a)
    );

    or1_rr_arb #(.N(2), .MAXHOLD(1)) dut_b (
        .CLK     (clk),
        .RSTN    (rstn_b),
        .REQ     (req_b),
        .GNT     (gnt_b),
        .OWNER   (owner_b),
        .BUSY    (busy_b),
        .TIMEOUT (timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rstn_a = 1'b0;
        req_a  = 4'b0000;
        tick();
        tick();
        rstn_a = 1'b1;
    endtask

    task automatic test_reset();
        reset_a();
        checks++;
        if (gnt_a !== 4'b0000 || busy_a !== 1'b0 || timeout_a !== 1'b0 || owner_a !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_state gnt=%b busy=%b to=%b owner=%0d expected 0000/0/0/0",
                     gnt_a, busy_a, timeout_a, owner_a);
        end
        req_a = 4'b0010;
        tick();
        checks++;
        if (gnt_a !== 4'b0010 || busy_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_pregrant gnt=%b busy=%b expected 0010/1", gnt_a, busy_a);
        end
        // Assert reset mid-cycle, well away from any clock edge.
        #2;
        rstn_a = 1'b0;
        #1;
        checks++;
        if (gnt_a !== 4'b0000 || busy_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async gnt=%b busy=%b expected 0000/0", gnt_a, busy_a);
        end
        req_a = 4'b0000;
        tick();
        rstn_a = 1'b1;
        // Pointer back at 0: with everyone requesting, requester 0 wins.
        req_a = 4'b1111;
        tick();
        checks++;
        if (gnt_a !== 4'b0001 || owner_a !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_ptr gnt=%b owner=%0d expected 0001/0", gnt_a, owner_a);
        end
        req_a = 4'b0000;
        tick();
        checks++;
        if (gnt_a !== 4'b0000 || busy_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release gnt=%b busy=%b expected 0000/0", gnt_a, busy_a);
        end
    endtask

    // Pointer is 1 on entry (requester 0 just released).
    task automatic test_single();
        req_a = 4'b0010;
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++;
            if (gnt_a !== 4'b0010 || owner_a !== 2'd1 || busy_a !== 1'b1) begin
                errors++;
                $display("[TB] FAIL single_hold edge%0d gnt=%b owner=%0d busy=%b expected 0010/1/1",
                         e, gnt_a, owner_a, busy_a);
            end
        end
        req_a = 4'b0000;
        tick();
        checks++;
        if (gnt_a !== 4'b0000 || owner_a !== 2'd1 || busy_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_drop gnt=%b owner=%0d busy=%b expected 0000/1/0",
                     gnt_a, owner_a, busy_a);
        end
        req_a = 4'b1111;
        tick();
        checks++;
        if (gnt_a !== 4'b0100 || owner_a !== 2'd2) begin
            errors++;
            $display("[TB] FAIL single_next gnt=%b owner=%0d expected 0100/2", gnt_a, owner_a);
        end
        req_a = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        logic [3:0] drop;
        reset_a();
        for (int i = 0; i < 5; i++) begin
            exp_gnt = 4'b0001 << (i % 4);
            req_a   = 4'b1111;
            tick();
            checks++;
            if (gnt_a !== exp_gnt || owner_a !== 2'(i % 4) || timeout_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d gnt=%b owner=%0d to=%b expected %b/%0d/0",
                         i, gnt_a, owner_a, timeout_a, exp_gnt, i % 4);
            end
            drop  = ~exp_gnt;
            req_a = drop;
            tick();
            checks++;
            if (gnt_a !== 4'b0000 || busy_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rr_idle%0d gnt=%b busy=%b expected 0000/0", i, gnt_a, busy_a);
            end
        end
        req_a = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        logic [3:0] exp_gnt;
        logic       exp_to;
        int         pulses;
        reset_a();
        pulses = 0;
        req_a  = 4'b0001;
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp_gnt = (e <= 4) ? 4'b0001 : 4'b0000;
            exp_to  = (e == 5);
            if (timeout_a === 1'b1) pulses++;
            checks++;
            if (gnt_a !== exp_gnt || timeout_a !== exp_to) begin
                errors++;
                $display("[TB] FAIL timeout_edge%0d gnt=%b to=%b expected %b/%b",
                         e, gnt_a, timeout_a, exp_gnt, exp_to);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL timeout_pulses count=%0d expected 1", pulses);
        end
        req_a = 4'b0000;
        tick();
        checks++;
        if (gnt_a !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL timeout_unmask gnt=%b expected 0000", gnt_a);
        end
        req_a = 4'b0001;
        tick();
        checks++;
        if (gnt_a !== 4'b0001 || timeout_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_regrant gnt=%b to=%b expected 0001/0", gnt_a, timeout_a);
        end
        req_a = 4'b0000;
        tick();
    endtask

    task automatic test_handoff();
        logic [3:0] exp_gnt;
        logic       exp_to;
        reset_a();
        req_a = 4'b0101;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e <= 4)                exp_gnt = 4'b0001;
            else if (e >= 6 && e <= 9) exp_gnt = 4'b0100;
            else                       exp_gnt = 4'b0000;
            exp_to = (e == 5) || (e == 10);
            checks++;
            if (gnt_a !== exp_gnt || timeout_a !== exp_to) begin
                errors++;
                $display("[TB] FAIL handoff_edge%0d gnt=%b to=%b expected %b/%b",
                         e, gnt_a, timeout_a, exp_gnt, exp_to);
            end
        end
        req_a = 4'b0000;
        tick();
    endtask

    task automatic test_maxhold1();
        logic [1:0] exp_gnt [4] = '{2'b01, 2'b00, 2'b10, 2'b00};
        logic       exp_to  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        rstn_b = 1'b0;
        req_b  = 2'b00;
        tick();
        rstn_b = 1'b1;
        for (int r = 0; r < 3; r++) begin
            req_b = 2'b11;
            for (int s = 0; s < 4; s++) begin
                tick();
                checks++;
                if (gnt_b !== exp_gnt[s] || timeout_b !== exp_to[s]) begin
                    errors++;
                    $display("[TB] FAIL mh1_r%0d_s%0d gnt=%b to=%b expected %b/%b",
                             r, s, gnt_b, timeout_b, exp_gnt[s], exp_to[s]);
                end
            end
            req_b = 2'b00;
            tick();
            checks++;
            if (gnt_b !== 2'b00 || timeout_b !== 1'b0 || busy_b !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mh1_drop%0d gnt=%b to=%b busy=%b expected 00/0/0",
                         r, gnt_b, timeout_b, busy_b);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        req_a  = 4'b0000;
        req_b  = 2'b00;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_handoff();
        test_maxhold1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
